// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit controller: access types, FSM states
// and the supported-access check.
package lsu_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic f3_supported(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for one access: byte enables and store data for both
// beats, split detection, and the shifted/extended load result.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rd0,
  input  logic [31:0] rd1,
  output logic        supported,
  output logic        split,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wd_lo,
  output logic [31:0] wd_hi,
  output logic [31:0] load_data
);

  logic [7:0]  base_mask;
  logic [7:0]  mask8;
  logic [31:0] size_mask;
  logic [2:0]  size_bytes;
  logic [63:0] wd64;
  logic [31:0] rd_sh;

  always_comb begin
    supported = f3_supported(we, funct3);

    case (funct3[1:0])
      2'b00: begin
        base_mask  = 8'h01;
        size_mask  = 32'h0000_00FF;
        size_bytes = 3'd1;
      end
      2'b01: begin
        base_mask  = 8'h03;
        size_mask  = 32'h0000_FFFF;
        size_bytes = 3'd2;
      end
      default: begin
        base_mask  = 8'h0F;
        size_mask  = 32'hFFFF_FFFF;
        size_bytes = 3'd4;
      end
    endcase

    // off + size never exceeds 7, so a 3-bit sum is enough
    split = (({1'b0, off} + size_bytes) > 3'd4);
    mask8 = base_mask << off;
    be_lo = mask8[3:0];
    be_hi = mask8[7:4];

    wd64  = {32'h0, wdata & size_mask} << {off, 3'b000};
    wd_lo = wd64[31:0];
    wd_hi = wd64[63:32];

    rd_sh = 32'({rd1, rd0} >> {off, 3'b000});
    case (funct3)
      F3_LB:   load_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
      F3_LH:   load_data = {{16{rd_sh[15]}}, rd_sh[15:0]};
      F3_LW:   load_data = rd_sh;
      F3_LBU:  load_data = {24'h0, rd_sh[7:0]};
      F3_LHU:  load_data = {16'h0, rd_sh[15:0]};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one access at a time, splits misaligned
// accesses into two word beats and returns a one-cycle response pulse.
//
// state    | meaning
// ST_IDLE  | ready for a new access
// ST_BEAT0 | first (or only) memory beat outstanding
// ST_BEAT1 | second beat of a split access outstanding
// ST_RESP  | response pulse cycle
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWe,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [31:0]       reqWdata,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [3:0]        memBe,
  output logic [31:0]       memWdata,
  input  logic              memAck,
  input  logic [31:0]       memRdata,
  output logic              rspValid,
  output logic [31:0]       rspData,
  output logic              rspErr
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd0_q, rd0_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              sel_req;
  logic              a_we;
  logic [2:0]        a_funct3;
  logic [1:0]        a_off;
  logic [31:0]       a_wdata;
  logic [31:0]       a_rd0;
  logic [31:0]       a_rd1;
  logic              a_supported;
  logic              a_split;
  logic [3:0]        a_be_lo, a_be_hi;
  logic [31:0]       a_wd_lo, a_wd_hi;
  logic [31:0]       a_load_data;

  // The aligner sees the live request in IDLE and the captured one afterwards;
  // the beat being acknowledged feeds memRdata straight in.
  always_comb begin
    sel_req  = (state_q == ST_IDLE);
    a_we     = sel_req ? reqWe       : we_q;
    a_funct3 = sel_req ? funct3      : funct3_q;
    a_off    = sel_req ? reqAddr[1:0] : off_q;
    a_wdata  = sel_req ? reqWdata    : wdata_q;
    a_rd0    = (state_q == ST_BEAT0) ? memRdata : rd0_q;
    a_rd1    = (state_q == ST_BEAT1) ? memRdata : 32'h0;
  end

  lsu_align u_align (
    .we        (a_we),
    .funct3    (a_funct3),
    .off       (a_off),
    .wdata     (a_wdata),
    .rd0       (a_rd0),
    .rd1       (a_rd1),
    .supported (a_supported),
    .split     (a_split),
    .be_lo     (a_be_lo),
    .be_hi     (a_be_hi),
    .wd_lo     (a_wd_lo),
    .wd_hi     (a_wd_hi),
    .load_data (a_load_data)
  );

  assign reqReady = (state_q == ST_IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    rd0_d       = rd0_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (reqValid && reqReady) begin
          we_d     = reqWe;
          funct3_d = funct3;
          off_d    = reqAddr[1:0];
          wdata_d  = reqWdata;
          if (a_supported) begin
            state_d     = ST_BEAT0;
            mem_req_d   = 1'b1;
            mem_we_d    = reqWe;
            mem_addr_d  = {reqAddr[ADDR_W-1:2], 2'b00};
            mem_be_d    = a_be_lo;
            mem_wdata_d = a_wd_lo;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 32'h0;
          end
        end
      end
      ST_BEAT0: begin
        if (memAck) begin
          rd0_d = memRdata;
          if (a_split) begin
            state_d     = ST_BEAT1;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_be_d    = a_be_hi;
            mem_wdata_d = a_wd_hi;
          end else begin
            state_d     = ST_RESP;
            mem_req_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = we_q ? 32'h0 : a_load_data;
          end
        end
      end
      ST_BEAT1: begin
        if (memAck) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = we_q ? 32'h0 : a_load_data;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= 32'h0;
      rd0_q       <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      rd0_q       <= rd0_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign memReq   = mem_req_q;
  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memBe    = mem_be_q;
  assign memWdata = mem_wdata_q;
  assign rspValid = rsp_valid_q;
  assign rspData  = rsp_data_q;
  assign rspErr   = rsp_err_q;

endmodule
